// File: rtl/core_clken_gen_if.sv
// ---------------------------------------------------------------------------
// core_clken_gen_if
//   Bundles the configuration and enable-output signals of core_clken_gen.
//
//   Signals
//     cfg_we     write the shadow registers of channel cfg_ch
//     cfg_ch     channel select (values >= NUM_CH are ignored)
//     cfg_inc    shadow increment value
//     cfg_phase  shadow start phase value
//     cfg_apply  one-cycle pulse: load all shadows into the live NCOs
//     run        1 = accumulators advance, 0 = hold
//     clken      per-channel one-cycle enable pulses
//     clkout     per-channel square waves (only with CLKGEN_SQUARE_OUT_EN)
//     locked     outputs settled since last reset release / apply
//
//   Protocol: there is no valid/ready handshake. Every configuration input
//   is sampled on each rising refclk edge; cfg_we and cfg_apply act for
//   exactly the cycles in which they are high, and the generator can never
//   stall the master.
//
//   Modports: master drives configuration, slave is the generator.
//   Optional macro: CLKGEN_SQUARE_OUT_EN adds clkout.
// ---------------------------------------------------------------------------
interface core_clken_gen_if #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 32
);
    logic              cfg_we;
    logic [3:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic              cfg_apply;
    logic              run;
    logic [NUM_CH-1:0] clken;
`ifdef CLKGEN_SQUARE_OUT_EN
    logic [NUM_CH-1:0] clkout;
`endif
    logic              locked;

`ifdef CLKGEN_SQUARE_OUT_EN
    modport master (
        output cfg_we, cfg_ch, cfg_inc, cfg_phase, cfg_apply, run,
        input  clken, clkout, locked
    );
    modport slave (
        input  cfg_we, cfg_ch, cfg_inc, cfg_phase, cfg_apply, run,
        output clken, clkout, locked
    );
`else
    modport master (
        output cfg_we, cfg_ch, cfg_inc, cfg_phase, cfg_apply, run,
        input  clken, locked
    );
    modport slave (
        input  cfg_we, cfg_ch, cfg_inc, cfg_phase, cfg_apply, run,
        output clken, locked
    );
`endif
endinterface

// File: rtl/core_clken_gen.sv
// ---------------------------------------------------------------------------
// core_clken_gen
//   Multi-channel fractional clock-enable generator. Each channel is an NCO:
//   acc advances by inc every refclk edge while run=1, and the carry out of
//   the ACC_W-bit sum becomes a one-cycle clken pulse on the next cycle.
//   f_out = f_refclk * inc / 2^ACC_W.
//
//   Ports
//     refclk   sole clock, rising edge
//     rst_n    asynchronous active-low reset
//     bus      core_clken_gen_if.slave (config in, clken/clkout/locked out)
//
//   Parameters
//     NUM_CH       number of channels (1..16)
//     ACC_W        accumulator / increment / phase width (8..48)
//     LOCK_CYCLES  edges after reset release or apply before locked rises
//
//   Optional macro: CLKGEN_SQUARE_OUT_EN adds registered clkout = acc MSB.
// ---------------------------------------------------------------------------
module core_clken_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 256
) (
    input  logic            refclk,
    input  logic            rst_n,
    core_clken_gen_if.slave bus
);
    localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    logic [ACC_W-1:0]  acc_q    [NUM_CH];
    logic [ACC_W-1:0]  acc_d    [NUM_CH];
    logic [ACC_W-1:0]  inc_q    [NUM_CH];
    logic [ACC_W-1:0]  inc_d    [NUM_CH];
    logic [ACC_W-1:0]  inc_sh_q [NUM_CH];
    logic [ACC_W-1:0]  inc_sh_d [NUM_CH];
    logic [ACC_W-1:0]  ph_sh_q  [NUM_CH];
    logic [ACC_W-1:0]  ph_sh_d  [NUM_CH];
    logic [ACC_W:0]    sum      [NUM_CH];
    logic [NUM_CH-1:0] clken_q, clken_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_q, locked_d;
`ifdef CLKGEN_SQUARE_OUT_EN
    logic [NUM_CH-1:0] clkout_q, clkout_d;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        locked_d = locked_q;
        clken_d  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            acc_d[ch]    = acc_q[ch];
            inc_d[ch]    = inc_q[ch];
            inc_sh_d[ch] = inc_sh_q[ch];
            ph_sh_d[ch]  = ph_sh_q[ch];
            // One extra bit so the wrap shows up as the carry.
            sum[ch]      = {1'b0, acc_q[ch]} + {1'b0, inc_q[ch]};
        end

        if (bus.cfg_apply) begin
            // Apply reads the shadow registers before any same-cycle write,
            // so a simultaneous write is held for the following apply.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc_d[ch] = ph_sh_q[ch];
                inc_d[ch] = inc_sh_q[ch];
            end
            cnt_d    = '0;
            locked_d = 1'b0;
        end else begin
            if (bus.run) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    acc_d[ch]   = sum[ch][ACC_W-1:0];
                    clken_d[ch] = sum[ch][ACC_W];
                end
            end
            // Lock timing is independent of run; the counter saturates.
            if (cnt_q != LOCK_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            locked_d = (cnt_d == LOCK_MAX);
        end

        // Channel numbers without a matching channel simply match nothing.
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bus.cfg_we && (bus.cfg_ch == 4'(ch))) begin
                inc_sh_d[ch] = bus.cfg_inc;
                ph_sh_d[ch]  = bus.cfg_phase;
            end
        end

`ifdef CLKGEN_SQUARE_OUT_EN
        for (int ch = 0; ch < NUM_CH; ch++) begin
            clkout_d[ch] = acc_d[ch][ACC_W-1];
        end
`endif
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc_q[ch]    <= '0;
                inc_q[ch]    <= '0;
                inc_sh_q[ch] <= '0;
                ph_sh_q[ch]  <= '0;
            end
            clken_q  <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
`ifdef CLKGEN_SQUARE_OUT_EN
            clkout_q <= '0;
`endif
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc_q[ch]    <= acc_d[ch];
                inc_q[ch]    <= inc_d[ch];
                inc_sh_q[ch] <= inc_sh_d[ch];
                ph_sh_q[ch]  <= ph_sh_d[ch];
            end
            clken_q  <= clken_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
`ifdef CLKGEN_SQUARE_OUT_EN
            clkout_q <= clkout_d;
`endif
        end
    end

    assign bus.clken  = clken_q;
    assign bus.locked = locked_q;
`ifdef CLKGEN_SQUARE_OUT_EN
    assign bus.clkout = clkout_q;
`endif

endmodule

// File: tb/tb_core_clken_gen.sv
// ---------------------------------------------------------------------------
// tb_core_clken_gen
//   Bench for core_clken_gen with ACC_W=8, NUM_CH=4, LOCK_CYCLES=16.
//   A behavioural model steps on each rising edge and pushes the expected
//   {clkout, locked, clken} word; the word is popped and compared on the
//   following falling edge. Directed timing checks sit on top.
//   Optional macro: CLKGEN_SQUARE_OUT_EN (clkout checks).
// ---------------------------------------------------------------------------
module tb_core_clken_gen;
    localparam int NUM_CH      = 4;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int MOD         = 1 << ACC_W;
`ifdef CLKGEN_SQUARE_OUT_EN
    localparam int EW = 2 * NUM_CH + 1;
`else
    localparam int EW = NUM_CH + 1;
`endif

    // ---------------- clock / reset ----------------
    logic refclk = 1'b0;
    logic rst_n  = 1'b1;
    always #5 refclk = ~refclk;

    core_clken_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

    core_clken_gen #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_acc [NUM_CH];
    int              m_inc [NUM_CH];
    int              m_ish [NUM_CH];
    int              m_psh [NUM_CH];
    int              m_cnt;
    bit              m_locked;
    bit [NUM_CH-1:0] m_clken;
    bit [NUM_CH-1:0] m_clkout;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_acc[c] = 0; m_inc[c] = 0; m_ish[c] = 0; m_psh[c] = 0;
        end
        m_cnt = 0; m_locked = 0; m_clken = '0; m_clkout = '0;
    endtask

    task automatic model_step();
        int s;
        if (bus.cfg_apply) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_acc[c]    = m_psh[c];
                m_inc[c]    = m_ish[c];
                m_clkout[c] = (m_acc[c] >= MOD / 2);
            end
            m_clken = '0; m_locked = 0; m_cnt = 0;
        end else begin
            if (bus.run) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    s           = m_acc[c] + m_inc[c];
                    m_clken[c]  = (s >= MOD);
                    m_acc[c]    = s % MOD;
                    m_clkout[c] = (m_acc[c] >= MOD / 2);
                end
            end else begin
                m_clken = '0;
            end
            if (m_cnt < LOCK_CYCLES) m_cnt++;
            if (m_cnt >= LOCK_CYCLES) m_locked = 1;
        end
        if (bus.cfg_we && int'(bus.cfg_ch) < NUM_CH) begin
            m_ish[bus.cfg_ch] = int'(bus.cfg_inc);
            m_psh[bus.cfg_ch] = int'(bus.cfg_phase);
        end
    endtask

    function automatic logic [EW-1:0] model_word();
`ifdef CLKGEN_SQUARE_OUT_EN
        return {m_clkout, m_locked, m_clken};
`else
        return {m_locked, m_clken};
`endif
    endfunction

    function automatic logic [EW-1:0] dut_word();
`ifdef CLKGEN_SQUARE_OUT_EN
        return {bus.clkout, bus.locked, bus.clken};
`else
        return {bus.locked, bus.clken};
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [EW-1:0] e;
        @(posedge refclk);
        model_step();
        exp_q.push_back(model_word());
        @(negedge refclk);
        e = exp_q.pop_front();
        check("sb", dut_word(), e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_sh(input int ch, input int inc, input int ph, input bit apply);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 4'(ch);
        bus.cfg_inc   = ACC_W'(inc);
        bus.cfg_phase = ACC_W'(ph);
        bus.cfg_apply = apply;
        tick();
        bus.cfg_we    = 1'b0;
        bus.cfg_apply = 1'b0;
    endtask

    task automatic do_apply();
        bus.cfg_apply = 1'b1;
        tick();
        bus.cfg_apply = 1'b0;
    endtask

    // Number of edges until clken[ch] is seen high; -1 if the bound expires.
    task automatic wait_pulse(input int ch, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.clken[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_locked(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.locked) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int cnt;
        bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_inc = '0; bus.cfg_phase = '0;
        bus.cfg_apply = 0; bus.run = 0;
        model_reset();

        #1 rst_n = 1'b0;
        #12;
        check("reset_outputs", dut_word(), '0);
        @(negedge refclk);
        rst_n = 1'b1;
        ticks(3);

        // 1: ch0 inc=0x40 -> pulse every 4th edge, first on the 4th after apply
        write_sh(0, 'h40, 'h00, 0);
        bus.run = 1'b1;
        do_apply();
        wait_pulse(0, 10, n);
        check("t1_first_pulse", n, 4);
        wait_pulse(0, 10, n);
        check("t1_period", n, 4);

        // 2: ch1 inc=0x80 phase=0x80 -> high after 1st edge, then every 2
        write_sh(1, 'h80, 'h80, 0);
        do_apply();
        wait_pulse(1, 10, n);
        check("t2_first_pulse", n, 1);
        wait_pulse(1, 10, n);
        check("t2_period", n, 2);

        // 3: lock timing, including a restart before lock
        do_apply();
        wait_locked(40, n);
        check("t3_lock_16", n, 16);
        do_apply();
        ticks(9);
        check("t3_unlocked_e9", bus.locked, 1'b0);
        do_apply();
        wait_locked(40, n);
        check("t3_lock_restart", n, 16);

        // 4: simultaneous write + apply -> ch2 idle until the next apply
        write_sh(2, 'h10, 'h00, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cnt += int'(bus.clken[2]);
        end
        check("t4_ch2_idle", cnt, 0);
        do_apply();
        wait_pulse(2, 40, n);
        check("t4_ch2_first", n, 16);
        wait_pulse(2, 40, n);
        check("t4_ch2_period", n, 16);

        // 5: out-of-range channel write is ignored; run=0 freezes the NCOs
        write_sh(7, 'hff, 'hff, 0);
        do_apply();
        wait_pulse(0, 10, n);
        check("t5_ch0_unchanged", n, 4);
        check("t5_ch3_idle", bus.clken[3], 1'b0);
        do_apply();
        ticks(2);
        bus.run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(bus.clken != '0);
        end
        check("t5_run0_no_pulses", cnt, 0);
        bus.run = 1'b1;
        wait_pulse(0, 10, n);
        check("t5_resume_phase", n, 2);

`ifdef CLKGEN_SQUARE_OUT_EN
        // 6: square output, inc=0x20 -> 4 low, 4 high
        write_sh(0, 'h20, 'h00, 0);
        do_apply();
        cnt = 0;
        n   = -1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (bus.clkout[0] && n < 0) n = i;
            cnt += int'(bus.clkout[0]);
        end
        check("t6_clkout_first_high", n, 4);
        check("t6_clkout_duty", cnt, 8);
`endif

        // Random configuration traffic, checked by the scoreboard only
        for (int i = 0; i < 300; i++) begin
            bus.cfg_we    = ($urandom_range(0, 3) == 0);
            bus.cfg_ch    = 4'($urandom_range(0, 7));
            bus.cfg_inc   = ACC_W'($urandom_range(0, MOD - 1));
            bus.cfg_phase = ACC_W'($urandom_range(0, MOD - 1));
            bus.cfg_apply = ($urandom_range(0, 19) == 0);
            bus.run       = ($urandom_range(0, 9) != 0);
            tick();
        end
        bus.cfg_we = 0; bus.cfg_apply = 0; bus.run = 1'b1;
        ticks(20);

        // Asynchronous reset in the middle of a run
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", dut_word(), '0);
        model_reset();
        @(negedge refclk);
        rst_n = 1'b1;
        ticks(20);
        check("midrun_relock", bus.locked, 1'b1);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
